// File: rtl/engine_arbiter_pkg.sv
// engine_arbiter_pkg: state encoding and default sizing shared by the arbiter files.
package engine_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 1023;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    LAUNCH  = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4,
    RELEASE = 3'd5
  } state_t;
endpackage

// File: rtl/engine_arbiter_rr_select.sv
// rr_select: round-robin pick of the first set req bit after ptr, with wrap.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  // Scan from farthest to nearest so the nearest set bit after ptr overwrites last.
  always_comb begin
    pick = '0;
    idx = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        pick = '0;
        pick[j] = 1'b1;
        idx = j;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/engine_arbiter.sv
// engine_arbiter: round-robin owner of one shared wrapper/engine.
// Optional job watchdog compiled in with ENGINE_ARB_WATCHDOG_EN.
module engine_arbiter
  import engine_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rdReq,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] cliDone,
  output logic               wrStart,
  output logic               wrRead,
  input  logic               wrReady,
  input  logic               wrDone,
  input  logic               wrEmpty,
  output logic               busy,
  output logic               err
);
  localparam int W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t state, nxt;
  logic [NUM_REQ-1:0] pick;
  logic [W-1:0] idx, ptr, own;
  logic any, to;
  logic unused_sink;
  rr_select #(.N(NUM_REQ), .W(W)) u_sel (
    .req (req),
    .ptr (ptr),
    .pick(pick),
    .idx (idx),
    .any (any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= W'(NUM_REQ - 1);
      own <= '0;
    end else begin
      state <= nxt;
      if (state == ARB) begin
        grant <= pick;
        own <= idx;
      end
      if (state == RELEASE) begin
        grant <= '0;
        ptr <= own;
      end
    end
  end
  always_comb begin
    nxt = state;
    wrStart = 1'b0;
    wrRead = 1'b0;
    cliDone = '0;
    case (state)
      IDLE:    nxt = (any && wrReady) ? ARB : IDLE;
      ARB:     nxt = any ? LAUNCH : IDLE;
      LAUNCH: begin
        wrStart = wrReady && !to;
        nxt = to ? RELEASE : wrReady ? RUN : LAUNCH;
      end
      RUN:     nxt = to ? RELEASE : wrDone ? DRAIN : RUN;
      DRAIN: begin
        cliDone = wrDone ? grant : '0;
        wrRead = rdReq[own];
        nxt = (to || wrReady) ? RELEASE : DRAIN;
      end
      RELEASE: nxt = any ? ARB : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
`ifdef ENGINE_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd;
  logic err_q, job;
  assign job = state == LAUNCH || state == RUN || state == DRAIN;
  assign to = job && wd == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= (state == ARB) ? '0 : job ? wd + CW'(1) : wd;
      if (to) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign to = 1'b0;
  assign err = 1'b0;
`endif
  // Completion is judged by wrReady; wrEmpty is informational only.
  assign unused_sink = wrEmpty ^ (TIMEOUT > 0);
endmodule
